// File: rtl/ft_byte_xcvr.sv
// FT245-style synchronous byte FIFO front end: packs RX bytes into little-endian
// 32-bit words and serialises TX words into bytes, with a stall-abort timer.
module ft_byte_xcvr #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ft_rxf_n,
    input  logic        ft_txe_n,
    input  logic [7:0]  ft_data_in,
    output logic [7:0]  ft_data_out,
    output logic        ft_data_oe,
    output logic        ft_oe_n,
    output logic        ft_rd_n,
    output logic        ft_wr_n,
    input  logic        rd_req,
    input  logic [9:0]  rd_word_cnt,
    input  logic        wr_req,
    input  logic [31:0] wr_data,
    output logic        rd_rdy,
    output logic        wr_rdy,
    output logic [31:0] rd_data,
    output logic        ft_data_valid,
    output logic        ft_done,
    output logic        xfer_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_TURN,
        RD_DATA,
        WR_DATA,
        FINISH
    } state_t;

    state_t      state, state_nxt;
    logic [9:0]  word_tgt, word_tgt_nxt;
    logic [9:0]  word_cnt, word_cnt_nxt;
    logic [1:0]  byte_idx, byte_idx_nxt;
    logic [15:0] stall_cnt, stall_cnt_nxt;
    logic [23:0] rx_asm, rx_asm_nxt;
    logic [23:0] tx_word, tx_word_nxt;
    logic        oe_n_nxt;
    logic        rd_n_nxt;
    logic        wr_n_nxt;
    logic        data_oe_nxt;
    logic [7:0]  data_out_nxt;
    logic [31:0] rd_data_nxt;
    logic        valid_nxt;
    logic        done_nxt;
    logic        timeout_nxt;
    logic        stall_hit;

    assign rd_rdy    = (state == IDLE) && !ft_rxf_n;
    assign wr_rdy    = (state == IDLE) && !ft_txe_n;
    assign stall_hit = (stall_cnt + 16'd1) == TIMEOUT_CYCLES;

    always_comb begin
        state_nxt     = state;
        word_tgt_nxt  = word_tgt;
        word_cnt_nxt  = word_cnt;
        byte_idx_nxt  = byte_idx;
        stall_cnt_nxt = stall_cnt;
        rx_asm_nxt    = rx_asm;
        tx_word_nxt   = tx_word;
        oe_n_nxt      = ft_oe_n;
        rd_n_nxt      = ft_rd_n;
        wr_n_nxt      = ft_wr_n;
        data_oe_nxt   = ft_data_oe;
        data_out_nxt  = ft_data_out;
        rd_data_nxt   = rd_data;
        valid_nxt     = 1'b0;
        done_nxt      = 1'b0;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                stall_cnt_nxt = '0;
                byte_idx_nxt  = '0;
                if (rd_req) begin
                    word_tgt_nxt = rd_word_cnt;
                    word_cnt_nxt = '0;
                    if (rd_word_cnt == 10'd0) begin
                        state_nxt = FINISH;
                    end else begin
                        oe_n_nxt  = 1'b0;
                        state_nxt = RD_TURN;
                    end
                end else if (wr_req) begin
                    tx_word_nxt  = wr_data[31:8];
                    data_out_nxt = wr_data[7:0];
                    data_oe_nxt  = 1'b1;
                    state_nxt    = WR_DATA;
                end
            end

            // Bus turnaround: FT drives the bus one cycle after OE# falls.
            RD_TURN: begin
                rd_n_nxt  = 1'b0;
                state_nxt = RD_DATA;
            end

            RD_DATA: begin
                if (!ft_rd_n && !ft_rxf_n) begin
                    stall_cnt_nxt = '0;
                    byte_idx_nxt  = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    rx_asm_nxt[7:0]   = ft_data_in;
                        2'd1:    rx_asm_nxt[15:8]  = ft_data_in;
                        2'd2:    rx_asm_nxt[23:16] = ft_data_in;
                        default: begin
                            rd_data_nxt  = {ft_data_in, rx_asm};
                            valid_nxt    = 1'b1;
                            word_cnt_nxt = word_cnt + 10'd1;
                            if ((word_cnt + 10'd1) == word_tgt) begin
                                done_nxt  = 1'b1;
                                rd_n_nxt  = 1'b1;
                                oe_n_nxt  = 1'b1;
                                state_nxt = IDLE;
                            end
                        end
                    endcase
                end else if (!ft_rd_n) begin
                    stall_cnt_nxt = stall_cnt + 16'd1;
                    if (stall_hit) begin
                        rd_n_nxt    = 1'b1;
                        oe_n_nxt    = 1'b1;
                        data_oe_nxt = 1'b0;
                        timeout_nxt = 1'b1;
                        done_nxt    = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end

            // First WR_DATA cycle only drops WR#; bytes move once it is low.
            WR_DATA: begin
                if (ft_wr_n) begin
                    wr_n_nxt = 1'b0;
                end else if (!ft_txe_n) begin
                    stall_cnt_nxt = '0;
                    byte_idx_nxt  = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    data_out_nxt = tx_word[7:0];
                        2'd1:    data_out_nxt = tx_word[15:8];
                        2'd2:    data_out_nxt = tx_word[23:16];
                        default: begin
                            wr_n_nxt    = 1'b1;
                            data_oe_nxt = 1'b0;
                            state_nxt   = FINISH;
                        end
                    endcase
                end else begin
                    stall_cnt_nxt = stall_cnt + 16'd1;
                    if (stall_hit) begin
                        wr_n_nxt    = 1'b1;
                        oe_n_nxt    = 1'b1;
                        rd_n_nxt    = 1'b1;
                        data_oe_nxt = 1'b0;
                        timeout_nxt = 1'b1;
                        done_nxt    = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end

            FINISH: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            word_tgt      <= '0;
            word_cnt      <= '0;
            byte_idx      <= '0;
            stall_cnt     <= '0;
            ft_oe_n       <= 1'b1;
            ft_rd_n       <= 1'b1;
            ft_wr_n       <= 1'b1;
            ft_data_oe    <= 1'b0;
            ft_data_out   <= '0;
            rd_data       <= '0;
            ft_data_valid <= 1'b0;
            ft_done       <= 1'b0;
            xfer_timeout  <= 1'b0;
        end else begin
            state         <= state_nxt;
            word_tgt      <= word_tgt_nxt;
            word_cnt      <= word_cnt_nxt;
            byte_idx      <= byte_idx_nxt;
            stall_cnt     <= stall_cnt_nxt;
            ft_oe_n       <= oe_n_nxt;
            ft_rd_n       <= rd_n_nxt;
            ft_wr_n       <= wr_n_nxt;
            ft_data_oe    <= data_oe_nxt;
            ft_data_out   <= data_out_nxt;
            rd_data       <= rd_data_nxt;
            ft_data_valid <= valid_nxt;
            ft_done       <= done_nxt;
            xfer_timeout  <= timeout_nxt;
        end
    end

    // Assembly and TX holding registers are pure data; stale contents are never observed.
    always_ff @(posedge sys_clk) begin
        rx_asm  <= rx_asm_nxt;
        tx_word <= tx_word_nxt;
    end

endmodule

// File: tb/tb_ft_byte_xcvr.sv
// Directed bench for ft_byte_xcvr: an FT chip model feeds/consumes bytes and
// monitors count output pulses; expected values are hand-computed constants.
module tb_ft_byte_xcvr;

    logic        sys_clk;
    logic        sys_rst;
    logic        ft_rxf_n;
    logic        ft_txe_n;
    logic [7:0]  ft_data_in;
    logic [7:0]  ft_data_out;
    logic        ft_data_oe;
    logic        ft_oe_n;
    logic        ft_rd_n;
    logic        ft_wr_n;
    logic        rd_req;
    logic [9:0]  rd_word_cnt;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        rd_rdy;
    logic        wr_rdy;
    logic [31:0] rd_data;
    logic        ft_data_valid;
    logic        ft_done;
    logic        xfer_timeout;

    ft_byte_xcvr #(.TIMEOUT_CYCLES(16'd16)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .ft_rxf_n     (ft_rxf_n),
        .ft_txe_n     (ft_txe_n),
        .ft_data_in   (ft_data_in),
        .ft_data_out  (ft_data_out),
        .ft_data_oe   (ft_data_oe),
        .ft_oe_n      (ft_oe_n),
        .ft_rd_n      (ft_rd_n),
        .ft_wr_n      (ft_wr_n),
        .rd_req       (rd_req),
        .rd_word_cnt  (rd_word_cnt),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .rd_rdy       (rd_rdy),
        .wr_rdy       (wr_rdy),
        .rd_data      (rd_data),
        .ft_data_valid(ft_data_valid),
        .ft_done      (ft_done),
        .xfer_timeout (xfer_timeout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  rx_mem [0:63];
    logic [7:0]  tx_log [0:15];
    logic [31:0] vld_log [0:15];
    int rx_ptr   = 0;
    int tx_cnt   = 0;
    int vld_cnt  = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int to_cnt   = 0;
    int rd_act   = 0;
    int wr_act   = 0;

    assign ft_data_in = rx_mem[rx_ptr[5:0]];

    // FT chip side: a byte moves on each edge with the strobe and flag both low.
    always @(posedge sys_clk) begin
        if (!ft_rd_n && !ft_rxf_n) rx_ptr <= rx_ptr + 1;
        if (!ft_wr_n && !ft_txe_n) begin
            tx_log[tx_cnt[3:0]] <= ft_data_out;
            tx_cnt <= tx_cnt + 1;
        end
    end

    always @(negedge sys_clk) begin
        if (ft_data_valid) begin
            vld_log[vld_cnt[3:0]] <= rd_data;
            vld_cnt <= vld_cnt + 1;
        end
        if (ft_done) done_cnt <= done_cnt + 1;
        if (ft_done && ft_data_valid) both_cnt <= both_cnt + 1;
        if (xfer_timeout) to_cnt <= to_cnt + 1;
        if (!ft_rd_n) rd_act <= rd_act + 1;
        if (!ft_wr_n) wr_act <= wr_act + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (ft_done !== 1'b1 && n < budget);
        chk(tag, 32'(ft_done), 32'd1);
    endtask

    task automatic start_read(input logic [9:0] cnt, input logic with_wr);
        rd_word_cnt = cnt;
        rd_req      = 1'b1;
        wr_req      = with_wr;
        @(negedge sys_clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    initial begin
        int base, d_vld, d_done, d_both, d_rd, d_wr, d_tx, d_to, n;

        #200000;
        $display("FAIL watchdog: got no end want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, d_vld, d_done, d_both, d_rd, d_wr, d_tx, d_to, n;

        for (int i = 0; i < 64; i++) rx_mem[i] = 8'h00;
        rx_mem[0] = 8'h01; rx_mem[1] = 8'h02; rx_mem[2] = 8'h03; rx_mem[3] = 8'h04;
        for (int i = 0; i < 12; i++) rx_mem[4 + i] = 8'(i);
        rx_mem[16] = 8'h11; rx_mem[17] = 8'h22; rx_mem[18] = 8'h33; rx_mem[19] = 8'h44;
        rx_mem[20] = 8'hA1; rx_mem[21] = 8'hA2;
        rx_mem[22] = 8'h55; rx_mem[23] = 8'h66; rx_mem[24] = 8'h77; rx_mem[25] = 8'h88;

        sys_rst     = 1'b1;
        ft_rxf_n    = 1'b1;
        ft_txe_n    = 1'b1;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        rd_word_cnt = '0;
        wr_data     = '0;
        repeat (3) @(negedge sys_clk);

        chk("rst_oe_n",    32'(ft_oe_n), 32'd1);
        chk("rst_rd_n",    32'(ft_rd_n), 32'd1);
        chk("rst_wr_n",    32'(ft_wr_n), 32'd1);
        chk("rst_data_oe", 32'(ft_data_oe), 32'd0);
        chk("rst_dout",    32'(ft_data_out), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_pulses",  32'({ft_data_valid, ft_done, xfer_timeout}), 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Ready flags follow the FIFO flags while idle.
        chk("rdy_none", 32'({rd_rdy, wr_rdy}), 32'd0);
        ft_rxf_n = 1'b0;
        ft_txe_n = 1'b0;
        #1;
        chk("rdy_both", 32'({rd_rdy, wr_rdy}), 32'd3);
        ft_txe_n = 1'b1;
        @(negedge sys_clk);

        // Single-word read.
        base = rx_ptr; d_vld = vld_cnt; d_done = done_cnt; d_both = both_cnt;
        start_read(10'd1, 1'b0);
        chk("rd1_rdy_busy", 32'(rd_rdy), 32'd0);
        wait_done("rd1_done_seen", 40);
        chk("rd1_vld_with_done", 32'(ft_data_valid), 32'd1);
        chk("rd1_data", rd_data, 32'h04030201);
        repeat (2) @(negedge sys_clk);
        chk("rd1_vld_cnt", 32'(vld_cnt - d_vld), 32'd1);
        chk("rd1_done_cnt", 32'(done_cnt - d_done), 32'd1);
        chk("rd1_both_cnt", 32'(both_cnt - d_both), 32'd1);
        chk("rd1_bytes", 32'(rx_ptr - base), 32'd4);
        chk("rd1_strobes_idle", 32'({ft_oe_n, ft_rd_n}), 32'd3);

        // Burst read of three words with a 5-cycle stall after byte 6.
        base = rx_ptr; d_vld = vld_cnt; d_done = done_cnt; d_both = both_cnt;
        start_read(10'd3, 1'b0);
        n = 0;
        while (rx_ptr < base + 6 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        chk("brst_six_bytes", 32'(rx_ptr - base), 32'd6);
        ft_rxf_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("brst_rd_n_held", 32'(ft_rd_n), 32'd0);
        chk("brst_stall_hold", 32'(rx_ptr - base), 32'd6);
        repeat (2) @(negedge sys_clk);
        ft_rxf_n = 1'b0;
        wait_done("brst_done_seen", 60);
        chk("brst_vld_with_done", 32'(ft_data_valid), 32'd1);
        repeat (2) @(negedge sys_clk);
        chk("brst_vld_cnt", 32'(vld_cnt - d_vld), 32'd3);
        chk("brst_w0", vld_log[d_vld % 16], 32'h03020100);
        chk("brst_w1", vld_log[(d_vld + 1) % 16], 32'h07060504);
        chk("brst_w2", vld_log[(d_vld + 2) % 16], 32'h0B0A0908);
        chk("brst_done_cnt", 32'(done_cnt - d_done), 32'd1);
        chk("brst_both_cnt", 32'(both_cnt - d_both), 32'd1);
        chk("brst_bytes", 32'(rx_ptr - base), 32'd12);

        // Single-word write with a TX-full stall after the second byte.
        ft_txe_n = 1'b0;
        d_tx = tx_cnt; d_done = done_cnt; d_vld = vld_cnt;
        wr_data = 32'hDEADBEEF;
        wr_req  = 1'b1;
        @(negedge sys_clk);
        wr_req = 1'b0;
        chk("wr_oe_on", 32'(ft_data_oe), 32'd1);
        n = 0;
        while (tx_cnt < d_tx + 2 && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        ft_txe_n = 1'b1;
        chk("wr_two_bytes", 32'(tx_cnt - d_tx), 32'd2);
        repeat (3) @(negedge sys_clk);
        chk("wr_stall_dout", 32'(ft_data_out), 32'h000000AD);
        chk("wr_stall_hold", 32'(tx_cnt - d_tx), 32'd2);
        ft_txe_n = 1'b0;
        wait_done("wr_done_seen", 40);
        chk("wr_oe_off", 32'(ft_data_oe), 32'd0);
        repeat (2) @(negedge sys_clk);
        chk("wr_bytes", 32'(tx_cnt - d_tx), 32'd4);
        chk("wr_b0", 32'(tx_log[d_tx % 16]), 32'h000000EF);
        chk("wr_b1", 32'(tx_log[(d_tx + 1) % 16]), 32'h000000BE);
        chk("wr_b2", 32'(tx_log[(d_tx + 2) % 16]), 32'h000000AD);
        chk("wr_b3", 32'(tx_log[(d_tx + 3) % 16]), 32'h000000DE);
        chk("wr_done_cnt", 32'(done_cnt - d_done), 32'd1);
        chk("wr_no_vld", 32'(vld_cnt - d_vld), 32'd0);

        // Simultaneous requests: read wins.
        d_wr = wr_act; d_tx = tx_cnt;
        wr_data = 32'hCAFEF00D;
        start_read(10'd1, 1'b1);
        wait_done("arb_done_seen", 40);
        chk("arb_rd_data", rd_data, 32'h44332211);
        repeat (2) @(negedge sys_clk);
        chk("arb_no_wr_n", 32'(wr_act - d_wr), 32'd0);
        chk("arb_no_tx", 32'(tx_cnt - d_tx), 32'd0);

        // Zero-length read finishes without touching RD#.
        d_rd = rd_act; d_vld = vld_cnt; base = rx_ptr;
        start_read(10'd0, 1'b0);
        @(negedge sys_clk);
        chk("zero_done_2cyc", 32'(ft_done), 32'd1);
        chk("zero_no_vld", 32'(ft_data_valid), 32'd0);
        repeat (2) @(negedge sys_clk);
        chk("zero_no_rd_n", 32'(rd_act - d_rd), 32'd0);
        chk("zero_no_bytes", 32'(rx_ptr - base), 32'd0);

        // Stall timeout after two bytes of a word.
        d_to = to_cnt; d_vld = vld_cnt;
        start_read(10'd1, 1'b0);
        n = 0;
        while (rx_ptr < 22 && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        ft_rxf_n = 1'b1;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (xfer_timeout !== 1'b1 && n < 40);
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_with_done", 32'(ft_done), 32'd1);
        chk("to_rd_data", rd_data, 32'h44332211);
        chk("to_strobes", 32'({ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe}), 32'hE);
        ft_rxf_n = 1'b0;
        #1;
        chk("to_idle_rdy", 32'(rd_rdy), 32'd1);
        @(negedge sys_clk);
        chk("to_single", 32'(xfer_timeout), 32'd0);
        repeat (2) @(negedge sys_clk);
        chk("to_cnt", 32'(to_cnt - d_to), 32'd1);
        chk("to_no_vld", 32'(vld_cnt - d_vld), 32'd0);

        // Asynchronous reset during a write, after the first byte.
        ft_txe_n = 1'b0;
        d_tx = tx_cnt;
        wr_data = 32'h12345678;
        wr_req  = 1'b1;
        @(negedge sys_clk);
        wr_req = 1'b0;
        n = 0;
        while (tx_cnt < d_tx + 1 && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        chk("arst_first_byte", 32'(tx_log[d_tx % 16]), 32'h00000078);
        chk("arst_wr_active", 32'({ft_wr_n, ft_data_oe}), 32'd1);
        d_done = done_cnt;
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_strobes", 32'({ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe}), 32'hE);
        chk("arst_dout", 32'(ft_data_out), 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("arst_no_done", 32'(done_cnt - d_done), 32'd0);

        start_read(10'd1, 1'b0);
        wait_done("post_rst_done_seen", 40);
        chk("post_rst_vld", 32'(ft_data_valid), 32'd1);
        chk("post_rst_data", rd_data, 32'h88776655);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
